// File: rtl/proc_pkg.sv
// Shared datapath definitions: word widths,
// op encodings and slot state for the demux.
package proc_pkg;

  localparam int WIDTH = 16;
  localparam int CNT_W = 8;

  localparam logic [1:0] OP_CH1 = 2'b00;
  localparam logic [1:0] OP_CH2 = 2'b01;
  localparam logic [1:0] OP_CH3 = 2'b10;
  localparam logic [1:0] OP_CH4 = 2'b11;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic logic [3:0] op_onehot(
    input logic [1:0] op
  );
    logic [3:0] sel;
    sel = 4'b0000;
    unique case (op)
      OP_CH1: sel = 4'b0001;
      OP_CH2: sel = 4'b0010;
      OP_CH3: sel = 4'b0100;
      OP_CH4: sel = 4'b1000;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/demux_slot.sv
// One output channel: holding register, valid
// flag and wrapping delivery counter.
module demux_slot
  import proc_pkg::*;
#(
  parameter int W  = WIDTH,
  parameter int CW = CNT_W
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          load_i,
  input  logic [W-1:0]  data_i,
  input  logic          ready_i,
  output logic [W-1:0]  data_o,
  output logic          valid_o,
  output logic [CW-1:0] cnt_o,
  output logic          free_o
);

  slot_state_e   state_q, state_d;
  logic [W-1:0]  data_q, data_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          drain;

  assign drain  = (state_q == SLOT_FULL) & ready_i;
  assign free_o = (state_q == SLOT_EMPTY) | ready_i;

  // Next state: refill wins over drain, data
  // register keeps its last word when emptied.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      state_d = SLOT_FULL;
      data_d  = data_i;
    end else if (drain) begin
      state_d = SLOT_EMPTY;
    end
    if (drain) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  // Slot registers, cleared by synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SLOT_EMPTY;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_o  = data_q;
  assign valid_o = (state_q == SLOT_FULL);
  assign cnt_o   = cnt_q;

endmodule

// File: rtl/demux4.sv
// 1-to-4 registered word distributor: op picks
// the channel, each channel has its own slot.
module demux4
  import proc_pkg::*;
#(
  parameter int WIDTH = proc_pkg::WIDTH,
  parameter int CNT_W = proc_pkg::CNT_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  input  logic [1:0]       op,
  output logic             in_ready,
  output logic [WIDTH-1:0] out1,
  output logic [WIDTH-1:0] out2,
  output logic [WIDTH-1:0] out3,
  output logic [WIDTH-1:0] out4,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [CNT_W-1:0] cnt1,
  output logic [CNT_W-1:0] cnt2,
  output logic [CNT_W-1:0] cnt3,
  output logic [CNT_W-1:0] cnt4
);

  logic [3:0]       sel;
  logic [3:0]       free;
  logic [3:0]       load;
  logic [WIDTH-1:0] data [4];
  logic [CNT_W-1:0] cnt  [4];

  assign sel      = op_onehot(op);
  assign in_ready = |(sel & free) & ~reset;
  assign load     = sel & {4{in_valid & in_ready}};

  for (genvar k = 0; k < 4; k++) begin : g_slot
    demux_slot #(
      .W  (WIDTH),
      .CW (CNT_W)
    ) u_slot (
      .clk_i   (clock),
      .rst_i   (reset),
      .load_i  (load[k]),
      .data_i  (in_data),
      .ready_i (out_ready[k]),
      .data_o  (data[k]),
      .valid_o (out_valid[k]),
      .cnt_o   (cnt[k]),
      .free_o  (free[k])
    );
  end

  assign out1 = data[0];
  assign out2 = data[1];
  assign out3 = data[2];
  assign out4 = data[3];
  assign cnt1 = cnt[0];
  assign cnt2 = cnt[1];
  assign cnt3 = cnt[2];
  assign cnt4 = cnt[3];

endmodule

// File: tb/tb_demux4.sv
// Bench for demux4: vector table, reference
// model and per-channel scoreboard queues.
module tb_demux4;

  logic        clock     = 1'b0;
  logic        reset     = 1'b1;
  logic [15:0] in_data   = '0;
  logic        in_valid  = 1'b0;
  logic [1:0]  op        = '0;
  logic [3:0]  out_ready = '0;
  logic        in_ready;
  logic [15:0] out1, out2, out3, out4;
  logic [3:0]  out_valid;
  logic [7:0]  cnt1, cnt2, cnt3, cnt4;

  always #5 clock = ~clock;

  demux4 dut (
    .clock     (clock),
    .reset     (reset),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .op        (op),
    .in_ready  (in_ready),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .out4      (out4),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .cnt1      (cnt1),
    .cnt2      (cnt2),
    .cnt3      (cnt3),
    .cnt4      (cnt4)
  );

  int checks = 0;
  int errors = 0;

  logic [15:0] mdat [4];
  logic [7:0]  mcnt [4];
  logic [3:0]  mv;
  logic [15:0] q0 [$];
  logic [15:0] q1 [$];
  logic [15:0] q2 [$];
  logic [15:0] q3 [$];

  typedef struct {
    logic        rs;
    logic        v;
    logic [1:0]  o;
    logic [15:0] d;
    logic [3:0]  r;
    logic        er;
    logic [3:0]  eov;
  } vec_t;

  vec_t tbl [$];

  function automatic logic [15:0] outv(input int k);
    case (k)
      0: return out1;
      1: return out2;
      2: return out3;
      default: return out4;
    endcase
  endfunction

  function automatic logic [7:0] cntv(input int k);
    case (k)
      0: return cnt1;
      1: return cnt2;
      2: return cnt3;
      default: return cnt4;
    endcase
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h",
               nm, act, exp);
    end
  endtask

  task automatic sb_push(input int k,
                         input logic [15:0] w);
    case (k)
      0: q0.push_back(w);
      1: q1.push_back(w);
      2: q2.push_back(w);
      default: q3.push_back(w);
    endcase
  endtask

  task automatic sb_pop(input int k,
                        output logic [15:0] w,
                        output logic ok);
    ok = 1'b1;
    w  = '0;
    case (k)
      0: if (q0.size() == 0) ok = 1'b0;
         else w = q0.pop_front();
      1: if (q1.size() == 0) ok = 1'b0;
         else w = q1.pop_front();
      2: if (q2.size() == 0) ok = 1'b0;
         else w = q2.pop_front();
      default: if (q3.size() == 0) ok = 1'b0;
         else w = q3.pop_front();
    endcase
  endtask

  task automatic model_clear();
    mv = '0;
    for (int k = 0; k < 4; k++) begin
      mdat[k] = '0;
      mcnt[k] = '0;
    end
    q0.delete();
    q1.delete();
    q2.delete();
    q3.delete();
  endtask

  // One clock: drive, check pre-edge, update
  // model, clock, check counters post-edge.
  task automatic cycle(input logic rs,
                       input logic v,
                       input logic [1:0] o,
                       input logic [15:0] d,
                       input logic [3:0] r,
                       output logic rdy);
    logic        er;
    logic        ok;
    logic [15:0] w;
    reset     = rs;
    in_valid  = v;
    op        = o;
    in_data   = d;
    out_ready = r;
    #2;
    er  = (!mv[o] | r[o]) & !rs;
    rdy = in_ready;
    chk("in_ready", {31'b0, in_ready}, {31'b0, er});
    chk("out_valid", {28'b0, out_valid}, {28'b0, mv});
    for (int k = 0; k < 4; k++)
      chk($sformatf("out%0d", k + 1),
          {16'b0, outv(k)}, {16'b0, mdat[k]});
    if (!rs) begin
      for (int k = 0; k < 4; k++) begin
        if (mv[k] & r[k]) begin
          sb_pop(k, w, ok);
          if (!ok) begin
            checks++;
            errors++;
            $display("FAIL sb_empty ch%0d: got handshake required none",
                     k + 1);
          end else begin
            chk($sformatf("sb_out%0d", k + 1),
                {16'b0, outv(k)}, {16'b0, w});
          end
          mcnt[k] = mcnt[k] + 8'd1;
          mv[k]   = 1'b0;
        end
      end
      if (v & er) begin
        sb_push(int'(o), d);
        mv[o]   = 1'b1;
        mdat[o] = d;
      end
    end else begin
      model_clear();
    end
    @(posedge clock);
    #1;
    for (int k = 0; k < 4; k++)
      chk($sformatf("cnt%0d", k + 1),
          {24'b0, cntv(k)}, {24'b0, mcnt[k]});
  endtask

  initial begin
    logic rdy;
    model_clear();
    @(posedge clock);
    #1;
    chk("rst_out_valid", {28'b0, out_valid}, 32'h0);
    chk("rst_out1", {16'b0, out1}, 32'h0);
    chk("rst_cnt4", {24'b0, cnt4}, 32'h0);
    chk("rst_in_ready", {31'b0, in_ready}, 32'h0);

    tbl.push_back('{1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b0, 4'b0000});
    tbl.push_back('{1'b0, 1'b1, 2'd2, 16'hA5A5, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd2, 16'h0000, 4'b0000, 1'b0, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0000, 1'b1, 4'b0100});
    tbl.push_back('{1'b0, 1'b0, 2'd0, 16'h0000, 4'b0100, 1'b1, 4'b0000});
    tbl.push_back('{1'b1, 1'b1, 2'd0, 16'hFFFF, 4'b1111, 1'b0, 4'b0000});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{1'b0, 1'b1, 2'(i % 4), 16'(i + 1),
                      4'b1111, 1'b1, 4'(1 << (i % 4))});
    tbl.push_back('{1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, 1'b1, 4'b0000});

    for (int i = 0; i < tbl.size(); i++) begin
      cycle(tbl[i].rs, tbl[i].v, tbl[i].o,
            tbl[i].d, tbl[i].r, rdy);
      chk($sformatf("vec%0d_rdy", i),
          {31'b0, rdy}, {31'b0, tbl[i].er});
      chk($sformatf("vec%0d_ov", i),
          {28'b0, out_valid}, {28'b0, tbl[i].eov});
      if (i == 1)
        chk("single_out3", {16'b0, out3}, 32'hA5A5);
    end
    chk("stream_cnt1", {24'b0, cnt1}, 32'd2);
    chk("stream_cnt2", {24'b0, cnt2}, 32'd2);
    chk("stream_cnt3", {24'b0, cnt3}, 32'd2);
    chk("stream_cnt4", {24'b0, cnt4}, 32'd2);

    cycle(1'b0, 1'b1, 2'd0, 16'h1111, 4'b0000, rdy);
    cycle(1'b0, 1'b1, 2'd0, 16'h2222, 4'b0001, rdy);
    chk("refill_rdy", {31'b0, rdy}, 32'd1);
    chk("refill_out1", {16'b0, out1}, 32'h2222);
    chk("refill_v0", {31'b0, out_valid[0]}, 32'd1);
    chk("refill_cnt1", {24'b0, cnt1}, 32'd3);
    cycle(1'b0, 1'b0, 2'd0, 16'h0000, 4'b0001, rdy);

    cycle(1'b1, 1'b0, 2'd0, 16'h0000, 4'b0000, rdy);
    for (int i = 1; i <= 256; i++) begin
      cycle(1'b0, 1'b1, 2'd3, 16'(i), 4'b1000, rdy);
      if (i == 256)
        chk("wrap_cnt4_255", {24'b0, cnt4}, 32'd255);
    end
    cycle(1'b0, 1'b0, 2'd0, 16'h0000, 4'b1000, rdy);
    chk("wrap_cnt4_0", {24'b0, cnt4}, 32'd0);
    chk("wrap_cnt1", {24'b0, cnt1}, 32'd0);
    chk("wrap_cnt2", {24'b0, cnt2}, 32'd0);
    chk("wrap_cnt3", {24'b0, cnt3}, 32'd0);

    for (int i = 0; i < 6; i++)
      cycle(1'b0, 1'b1, 2'd1, 16'h0200 + 16'(i),
            4'b0010, rdy);
    cycle(1'b0, 1'b1, 2'd0, 16'hC001, 4'b0000, rdy);
    cycle(1'b0, 1'b1, 2'd2, 16'hC003, 4'b0000, rdy);
    cycle(1'b0, 1'b1, 2'd3, 16'hC004, 4'b0000, rdy);
    chk("pre_rst_cnt2", {24'b0, cnt2}, 32'd5);
    chk("pre_rst_ov", {28'b0, out_valid}, 32'hF);
    cycle(1'b1, 1'b1, 2'd1, 16'hDEAD, 4'b1111, rdy);
    chk("mid_rst_rdy", {31'b0, rdy}, 32'd0);
    chk("mid_rst_ov", {28'b0, out_valid}, 32'h0);
    chk("mid_rst_cnt2", {24'b0, cnt2}, 32'd0);
    chk("mid_rst_out2", {16'b0, out2}, 32'h0);
    chk("mid_rst_out4", {16'b0, out4}, 32'h0);

    cycle(1'b0, 1'b1, 2'd1, 16'hBEEF, 4'b0000, rdy);
    cycle(1'b0, 1'b1, 2'd0, 16'h0A00, 4'b1101, rdy);
    chk("iso_rdy_op0", {31'b0, rdy}, 32'd1);
    cycle(1'b0, 1'b1, 2'd2, 16'h0A02, 4'b1101, rdy);
    chk("iso_rdy_op2", {31'b0, rdy}, 32'd1);
    cycle(1'b0, 1'b1, 2'd3, 16'h0A03, 4'b1101, rdy);
    chk("iso_rdy_op3", {31'b0, rdy}, 32'd1);
    cycle(1'b0, 1'b1, 2'd1, 16'h0A01, 4'b1101, rdy);
    chk("iso_rdy_op1", {31'b0, rdy}, 32'd0);
    chk("iso_out2", {16'b0, out2}, 32'hBEEF);
    chk("iso_v1", {31'b0, out_valid[1]}, 32'd1);
    cycle(1'b0, 1'b0, 2'd0, 16'h0000, 4'b1111, rdy);
    chk("iso_cnt2", {24'b0, cnt2}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
